// File: rtl/ram_rw_clr.sv
// Single-clock RAM with independent write/read ports, registered read with
// valid/error strobes, write-first bypass and a clear sweep after reset or on request.
module ram_rw_clr #(
  parameter int               WIDTH     = 4,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] CLR_VALUE = '0,
  localparam int              AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             rd_err,
  input  logic             clr_req,
  output logic             busy
);

  // One extra bit so the range compare works when DEPTH is a power of two.
  localparam logic [AW:0]   DEPTH_X = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t           state, state_next;
  logic [AW-1:0]    clr_ptr, clr_ptr_next;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             rd_take;
  logic             wr_in_range, rd_in_range;

  logic [WIDTH-1:0] mem [DEPTH];

  assign wr_in_range = {1'b0, wr_addr} < DEPTH_X;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_X;
  assign busy        = (state == CLEAR);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_next;
      clr_ptr <= clr_ptr_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_next   = state;
    clr_ptr_next = clr_ptr;
    mem_we       = 1'b0;
    mem_addr     = wr_addr;
    mem_wdata    = wr_data;
    rd_take      = 1'b0;
    unique case (state)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = clr_ptr;
        mem_wdata = CLR_VALUE;
        if (clr_ptr == LAST) begin
          state_next   = IDLE;
          clr_ptr_next = '0;
        end else begin
          clr_ptr_next = clr_ptr + AW'(1);
        end
      end
      IDLE: begin
        if (clr_req) begin
          state_next = CLEAR;
        end else begin
          mem_we  = wr_en && wr_in_range;
          rd_take = rd_en;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  // NOTE: the array has no reset; the clear sweep initialises it, which keeps
  // it mappable onto RAM macros.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_take;
      rd_err   <= rd_take && !rd_in_range;
      if (rd_take) begin
        if (!rd_in_range)                     rd_data <= '0;
        else if (wr_en && wr_addr == rd_addr) rd_data <= wr_data;
        else                                  rd_data <= mem[rd_addr];
      end
    end
  end

endmodule

// File: tb/tb_ram_rw_clr.sv
// Directed and random stimulus for ram_rw_clr (8x5, clear value A5), checked
// against a per-edge behavioural model of the RAM contents and read port.
module tb_ram_rw_clr;

  localparam int         WIDTH = 8;
  localparam int         DEPTH = 5;
  localparam logic [7:0] CLR   = 8'hA5;

  logic       clk, reset;
  logic       wr_en, rd_en, clr_req;
  logic [2:0] wr_addr, rd_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       rd_valid, rd_err, busy;

  ram_rw_clr #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CLR_VALUE(CLR)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err),
    .clr_req(clr_req), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  string      step   = "init";

  // Reference model: word array, sweep edges still owed, and expected outputs.
  logic [7:0] mem_m [DEPTH];
  int         sweep_left;
  logic [7:0] exp_data;
  logic       exp_valid, exp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=%0h expected=%0h", step, tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("rd_valid", 32'(rd_valid), 32'(exp_valid));
    check("rd_err",   32'(rd_err),   32'(exp_err));
    check("rd_data",  32'(rd_data),  32'(exp_data));
    check("busy",     32'(busy),     32'(sweep_left > 0));
  endtask

  // One clock edge: drive inputs, advance the model by the rules, compare.
  task automatic cyc(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                     input logic re, input logic [2:0] ra, input logic cr);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr = ra; clr_req = cr;
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    if (sweep_left > 0) begin
      mem_m[DEPTH - sweep_left] = CLR;
      sweep_left--;
    end else if (cr) begin
      sweep_left = DEPTH;
    end else begin
      if (re) begin
        exp_valid = 1'b1;
        if (int'(ra) >= DEPTH) begin
          exp_data = 8'h00;
          exp_err  = 1'b1;
        end else if (we && wa == ra) begin
          exp_data = wd;
        end else begin
          exp_data = mem_m[ra];
        end
      end
      if (we && int'(wa) < DEPTH) mem_m[wa] = wd;
    end
    check_outputs();
  endtask

  task automatic idle();
    cyc(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cyc(1'b1, a, d, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic rd(input logic [2:0] a);
    cyc(1'b0, 3'd0, 8'h00, 1'b1, a, 1'b0);
  endtask

  // Asynchronous reset applied between edges, held for 'hold' edges.
  task automatic do_reset(input int hold);
    reset = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
    #1;
    sweep_left = DEPTH;
    exp_data   = 8'h00;
    exp_valid  = 1'b0;
    exp_err    = 1'b0;
    check_outputs();
    repeat (hold) @(posedge clk);
    #1;
    reset = 1'b0;
    check_outputs();
  endtask

  initial begin
    logic [7:0] pat [5];
    pat[0] = 8'h03; pat[1] = 8'h0C; pat[2] = 8'h05; pat[3] = 8'h0F; pat[4] = 8'h77;
    wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    reset = 1'b0;
    #2;

    step = "reset_init";
    do_reset(2);
    for (int i = 0; i < DEPTH; i++) idle();
    check("busy_done", 32'(busy), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      rd(3'(i));
      check("init_word", 32'(rd_data), 32'(CLR));
    end
    idle();

    step = "write_read";
    for (int i = 0; i < DEPTH; i++) wr(3'(i), pat[i]);
    for (int i = 3; i >= 0; i--) begin
      rd(3'(i));
      check("b2b_word", 32'(rd_data), 32'(pat[i]));
      check("b2b_valid", 32'(rd_valid), 32'd1);
    end
    idle();

    step = "bypass";
    cyc(1'b1, 3'd2, 8'h09, 1'b1, 3'd2, 1'b0);
    check("bypass_word", 32'(rd_data), 32'h09);
    rd(3'd2);
    check("after_bypass", 32'(rd_data), 32'h09);
    cyc(1'b1, 3'd4, 8'h3C, 1'b1, 3'd1, 1'b0);

    step = "out_of_range";
    wr(3'd6, 8'h11);
    rd(3'd6);
    check("oor_err", 32'(rd_err), 32'd1);
    check("oor_data", 32'(rd_data), 32'd0);
    for (int i = 0; i < DEPTH; i++) rd(3'(i));
    rd(3'd7);
    idle();

    step = "clear_priority";
    cyc(1'b1, 3'd1, 8'h07, 1'b1, 3'd1, 1'b1);
    check("clr_no_valid", 32'(rd_valid), 32'd0);
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 3'd0, 8'h5A, 1'b1, 3'd0, (i == 1 || i == 4));
    check("clr_not_extended", 32'(busy), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      rd(3'(i));
      check("clr_word", 32'(rd_data), 32'(CLR));
    end
    for (int i = 0; i < DEPTH; i++) wr(3'(i), pat[i]);

    step = "reset_mid_sweep";
    cyc(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1);
    idle();
    idle();
    do_reset(1);
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 3'd1, 8'hEE, 1'b1, 3'd1, 1'b0);
    for (int i = 0; i < DEPTH; i++) rd(3'(i));

    step = "random";
    for (int n = 0; n < 600; n++) begin
      logic       we, re, cr;
      logic [2:0] wa, ra;
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      cr = ($urandom_range(0, 39) == 0);
      wa = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
      cyc(we, wa, 8'($urandom), re, ra, cr);
      if (n == 300) do_reset(1 + int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
